// File: rtl/lp805x_fsdiv_pkg.sv
// lp805x_fsdiv_pkg
// Shared definitions for the frequency-scale divider and its request register:
// prescaler range, counter width, the one-bit FSM encoding and the
// index-to-terminal-count mapping.
package lp805x_fsdiv_pkg;

   // Highest prescaler index. Index TOP_PRESCALER divides by 1 and index 0
   // divides by 2^TOP_PRESCALER.
   localparam int TOP_PRESCALER = 7;

   // The divide counter must be able to hold 2^TOP_PRESCALER - 1.
   localparam int CNT_W = TOP_PRESCALER;
   localparam int IDX_W = 3;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } fsdiv_state_e;

   // Terminal count for an index: (1 << (TOP_PRESCALER - idx)) - 1.
   // The shift is done one bit wider so that index 0 (divide by 128) does not
   // overflow before the subtraction.
   function automatic logic [CNT_W-1:0] div_term(input logic [IDX_W-1:0] idx);
      logic [CNT_W:0] div;
      div = (CNT_W+1)'(1) << (TOP_PRESCALER - int'(idx));
      div = div - (CNT_W+1)'(1);
      return div[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/lp805x_fsdiv_req.sv
// lp805x_fsdiv_req
// Pending/acknowledge register for a scheduler result crossing into a timed
// domain. A load captures the requested index; the owner raises apply_i at a
// point where the request may take effect, and the register answers with a
// one-cycle ack.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   load_i        capture index_i as the pending request
//   index_i       requested index
//   apply_i       owner is consuming pend_index_o this cycle (only while pending)
//   pend_index_o  index waiting to be applied
//   pending_o     a captured request is waiting
//   ack_o         one-cycle pulse in the cycle after a request was applied
module lp805x_fsdiv_req
   import lp805x_fsdiv_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic             apply_i,
   output logic [IDX_W-1:0] pend_index_o,
   output logic             pending_o,
   output logic             ack_o
);

   logic [IDX_W-1:0] pend_index_q, pend_index_d;
   logic             pending_q, pending_d;
   logic             ack_q, ack_d;

   always_comb begin
      pend_index_d = pend_index_q;
      pending_d    = pending_q;
      ack_d        = apply_i & pending_q;
      if (apply_i && pending_q) begin
         pending_d = 1'b0;
      end
      // A load on the same edge as an application wins: the old value has just
      // been consumed and the new one becomes the next request.
      if (load_i) begin
         pend_index_d = index_i;
         pending_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_index_q <= IDX_W'(TOP_PRESCALER);
         pending_q    <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         pend_index_q <= pend_index_d;
         pending_q    <= pending_d;
         ack_q        <= ack_d;
      end
   end

   assign pend_index_o = pend_index_q;
   assign pending_o    = pending_q;
   assign ack_o        = ack_q;

endmodule

// File: rtl/lp805x_fsdiv.sv
// lp805x_fsdiv
// Frequency-scale divider: turns the scheduler's prescaler index into a
// periodic one-cycle clock-enable tick. Index changes are deferred to a period
// boundary (or to the stopped state) so no period is ever cut short or
// stretched.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   enable_i     run the divider; low holds counter and tick idle
//   index_i      requested prescaler index (7 = /1 ... 0 = /128)
//   load_i       one-cycle strobe capturing index_i as the pending request
//   tick_o       registered clock-enable pulse, once per period
//   cur_index_o  index currently in effect
//   pending_o    a captured request is waiting for a boundary
//   ack_o        one-cycle pulse in the cycle after a new index became active
module lp805x_fsdiv
   import lp805x_fsdiv_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic             load_i,
   output logic             tick_o,
   output logic [IDX_W-1:0] cur_index_o,
   output logic             pending_o,
   output logic             ack_o
);

   fsdiv_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [IDX_W-1:0] cur_index_q, cur_index_d;

   logic [CNT_W-1:0] term;
   logic             apply;
   logic [IDX_W-1:0] pend_index;
   logic             pending;

   lp805x_fsdiv_req u_req (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .load_i       (load_i),
      .index_i      (index_i),
      .apply_i      (apply),
      .pend_index_o (pend_index),
      .pending_o    (pending),
      .ack_o        (ack_o)
   );

   assign term = div_term(cur_index_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      apply   = 1'b0;
      unique case (state_q)
         STOP: begin
            // Nothing is counting, so any pending index can take effect at once.
            cnt_d = '0;
            apply = pending;
            if (enable_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable_i) begin
               // Abandon the partial period; a pending index waits for STOP.
               state_d = STOP;
               cnt_d   = '0;
            end else if (cnt_q == term) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               apply  = pending;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STOP;
            cnt_d   = '0;
         end
      endcase
      cur_index_d = apply ? pend_index : cur_index_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= STOP;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         cur_index_q <= IDX_W'(TOP_PRESCALER);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         cur_index_q <= cur_index_d;
      end
   end

   assign tick_o      = tick_q;
   assign cur_index_o = cur_index_q;
   assign pending_o   = pending;

endmodule
